// File: rtl/forwarding_tracker.sv
`default_nettype none
// ============================================================================
// forwarding_tracker : issue-point forwarding/hazard unit with own producer history
// Revision 1.0
// ============================================================================
module forwarding_tracker #(
    parameter int REG_ADDRESS_LEN = 4,
    parameter int NUM_SRC         = 2,
    parameter int FWD_DEPTH       = 2,
    parameter int LOAD_LAT        = 2,
    parameter int SEL_W           = $clog2(FWD_DEPTH + 1)
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               en_forwarding,
    input  logic                               freeze,
    input  logic                               flush,
    input  logic                               issue_valid,
    input  logic                               issue_wb_en,
    input  logic                               issue_mem_read,
    input  logic [REG_ADDRESS_LEN-1:0]         issue_dst,
    input  logic [NUM_SRC*REG_ADDRESS_LEN-1:0] id_src,
    input  logic [NUM_SRC-1:0]                 id_src_used,
    output logic [NUM_SRC*SEL_W-1:0]           sel_src,
    output logic                               hazard_stall,
    output logic [15:0]                        stall_count,
    output logic [15:0]                        fwd_count
);

    // Index k-1 of each slot vector holds slot k (slot 1 = youngest).
    logic [FWD_DEPTH-1:0]       r_valid;
    logic [FWD_DEPTH-1:0]       r_wb_en;
    logic [FWD_DEPTH-1:0]       r_mem_read;
    logic [REG_ADDRESS_LEN-1:0] r_dst [FWD_DEPTH];
    logic [15:0]                r_stall_count;
    logic [15:0]                r_fwd_count;

    logic [NUM_SRC-1:0] w_src_stall;
    logic [NUM_SRC-1:0] w_src_fwd;
    logic               w_accept;

    generate
        for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
            logic [SEL_W-1:0] w_win;
            logic             w_win_load;

            // Scan oldest to youngest so the youngest match is written last.
            always_comb begin
                w_win      = '0;
                w_win_load = 1'b0;
                for (int k = FWD_DEPTH; k >= 1; k--) begin
                    if (id_src_used[i] && r_valid[k-1] && r_wb_en[k-1] &&
                        (r_dst[k-1] == id_src[i*REG_ADDRESS_LEN +: REG_ADDRESS_LEN])) begin
                        w_win      = SEL_W'(k);
                        w_win_load = r_mem_read[k-1];
                    end
                end
            end

            assign w_src_stall[i] = en_forwarding ? (w_win_load && (int'(w_win) < LOAD_LAT))
                                                  : (w_win != '0);
            assign w_src_fwd[i]   = en_forwarding && (w_win != '0);
            assign sel_src[i*SEL_W +: SEL_W] = en_forwarding ? w_win : '0;
        end
    endgenerate

    assign hazard_stall = issue_valid && (|w_src_stall);
    assign w_accept     = issue_valid && !hazard_stall && !flush;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid       <= '0;
            r_stall_count <= '0;
            r_fwd_count   <= '0;
        end else if (!freeze) begin
            r_valid[0] <= w_accept;
            for (int k = 1; k < FWD_DEPTH; k++) begin
                r_valid[k] <= r_valid[k-1];
            end
            if (hazard_stall && (r_stall_count != 16'hFFFF)) begin
                r_stall_count <= r_stall_count + 16'd1;
            end
            if (w_accept && (|w_src_fwd) && (r_fwd_count != 16'hFFFF)) begin
                r_fwd_count <= r_fwd_count + 16'd1;
            end
        end
    end

    // Payload fields are only meaningful under r_valid, so they carry no reset.
    always_ff @(posedge clk) begin
        if (!freeze) begin
            r_wb_en[0]    <= issue_wb_en;
            r_mem_read[0] <= issue_mem_read;
            r_dst[0]      <= issue_dst;
            for (int k = 1; k < FWD_DEPTH; k++) begin
                r_wb_en[k]    <= r_wb_en[k-1];
                r_mem_read[k] <= r_mem_read[k-1];
                r_dst[k]      <= r_dst[k-1];
            end
        end
    end

    assign stall_count = r_stall_count;
    assign fwd_count   = r_fwd_count;

endmodule
`default_nettype wire

// File: tb/tb_forwarding_tracker.sv
`default_nettype none
// ============================================================================
// tb_forwarding_tracker : directed + randomized checks against a history-queue model
// Revision 1.0
// ============================================================================
module tb_forwarding_tracker;

    localparam int LL       = 2;
    localparam int SAT_D    = 31;
    localparam int SAT_EDGE = 68000;

    logic        clk, rst;
    logic        en_forwarding, freeze, flush, issue_valid, issue_wb_en, issue_mem_read;
    logic [3:0]  issue_dst;
    logic [7:0]  id_src;
    logic [1:0]  id_src_used;
    logic [3:0]  sel_src;
    logic        hazard_stall;
    logic [15:0] stall_count, fwd_count;

    logic        s_en_forwarding, s_freeze, s_flush, s_issue_valid, s_issue_wb_en, s_issue_mem_read;
    logic [3:0]  s_issue_dst;
    logic [7:0]  s_id_src;
    logic [1:0]  s_id_src_used;
    logic [9:0]  s_sel_src;
    logic        s_hazard_stall;
    logic [15:0] s_stall_count, s_fwd_count;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        bit       v;
        bit       wb;
        bit       mr;
        bit [3:0] dst;
    } slot_t;

    slot_t hist[$];   // hist[0] is slot 1
    int    m_stall;
    int    m_fwd;

    forwarding_tracker dut (
        .clk(clk), .rst(rst), .en_forwarding(en_forwarding), .freeze(freeze), .flush(flush),
        .issue_valid(issue_valid), .issue_wb_en(issue_wb_en), .issue_mem_read(issue_mem_read),
        .issue_dst(issue_dst), .id_src(id_src), .id_src_used(id_src_used), .sel_src(sel_src),
        .hazard_stall(hazard_stall), .stall_count(stall_count), .fwd_count(fwd_count)
    );

    forwarding_tracker #(.FWD_DEPTH(SAT_D)) u_sat (
        .clk(clk), .rst(rst), .en_forwarding(s_en_forwarding), .freeze(s_freeze), .flush(s_flush),
        .issue_valid(s_issue_valid), .issue_wb_en(s_issue_wb_en), .issue_mem_read(s_issue_mem_read),
        .issue_dst(s_issue_dst), .id_src(s_id_src), .id_src_used(s_id_src_used), .sel_src(s_sel_src),
        .hazard_stall(s_hazard_stall), .stall_count(s_stall_count), .fwd_count(s_fwd_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1500000;
        $display("FAIL watchdog expired observed=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        hist.delete();
        for (int k = 0; k < 2; k++) hist.push_back('{v: 0, wb: 0, mr: 0, dst: 0});
        m_stall = 0;
        m_fwd   = 0;
    endtask

    function automatic void model_out(output bit [3:0] sel, output bit stall);
        sel   = '0;
        stall = 1'b0;
        for (int i = 0; i < 2; i++) begin
            bit [3:0] a;
            int       kw;
            a  = id_src[i*4 +: 4];
            kw = 0;
            for (int k = 0; k < hist.size(); k++)
                if (kw == 0 && id_src_used[i] && hist[k].v && hist[k].wb && hist[k].dst == a)
                    kw = k + 1;
            if (en_forwarding) begin
                sel[i*2 +: 2] = 2'(kw);
                if (kw != 0 && hist[kw-1].mr && kw < LL) stall = 1'b1;
            end else if (kw != 0) begin
                stall = 1'b1;
            end
        end
        stall = stall && issue_valid;
    endfunction

    task automatic drive(input bit v, input bit wb, input bit mr, input bit [3:0] dst,
                         input bit [3:0] s0, input bit [3:0] s1, input bit [1:0] used,
                         input bit en, input bit frz, input bit fl);
        @(negedge clk);
        issue_valid    = v;
        issue_wb_en    = wb;
        issue_mem_read = mr;
        issue_dst      = dst;
        id_src         = {s1, s0};
        id_src_used    = used;
        en_forwarding  = en;
        freeze         = frz;
        flush          = fl;
        #1;
    endtask

    // Compare comb outputs with the model, clock once, advance the model, compare counters.
    task automatic tick();
        bit [3:0] es;
        bit       est;
        bit       acc;
        model_out(es, est);
        check("sel_model", sel_src, es);
        check("stall_model", hazard_stall, est);
        acc = issue_valid && !est && !flush;
        @(posedge clk);
        if (!freeze) begin
            if (est) m_stall = (m_stall < 16'hFFFF) ? m_stall + 1 : m_stall;
            if (acc && es != 0) m_fwd = (m_fwd < 16'hFFFF) ? m_fwd + 1 : m_fwd;
            hist.push_front(acc ? '{v: 1, wb: issue_wb_en, mr: issue_mem_read, dst: issue_dst}
                                : '{v: 0, wb: 0, mr: 0, dst: 0});
            void'(hist.pop_back());
        end
        #1;
        check("stall_count_model", stall_count, m_stall);
        check("fwd_count_model", fwd_count, m_fwd);
    endtask

    initial begin
        rst = 1'b1;
        issue_valid = 0; issue_wb_en = 0; issue_mem_read = 0; issue_dst = 0;
        id_src = 8'h33; id_src_used = 2'b11; en_forwarding = 1; freeze = 0; flush = 0;
        s_en_forwarding = 0; s_freeze = 0; s_flush = 0; s_issue_valid = 0; s_issue_wb_en = 0;
        s_issue_mem_read = 0; s_issue_dst = 0; s_id_src = 0; s_id_src_used = 0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("reset_sel", sel_src, 0);
        check("reset_stall", hazard_stall, 0);
        check("reset_stall_count", stall_count, 0);
        check("reset_fwd_count", fwd_count, 0);

        // Basic forwarding of R3
        drive(1, 1, 0, 3, 0, 0, 2'b00, 1, 0, 0);
        check("w3_nostall", hazard_stall, 0);
        tick();
        drive(1, 0, 0, 0, 3, 3, 2'b11, 1, 0, 0);
        check("fwd_r3_slot1", sel_src, 4'b0101);
        tick();
        drive(1, 0, 0, 0, 3, 3, 2'b11, 1, 0, 0);
        check("fwd_r3_slot2", sel_src, 4'b1010);
        tick();
        drive(1, 0, 0, 0, 3, 3, 2'b11, 1, 0, 0);
        check("fwd_r3_gone", sel_src, 4'b0000);
        tick();
        check("fwd_count_basic", fwd_count, 2);

        // Youngest of two R5 writers wins
        drive(1, 1, 0, 5, 0, 0, 2'b00, 1, 0, 0);
        tick();
        drive(1, 1, 0, 5, 0, 0, 2'b00, 1, 0, 0);
        tick();
        drive(1, 0, 0, 0, 5, 0, 2'b01, 1, 0, 0);
        check("prio_sel", sel_src, 4'b0001);
        tick();
        check("prio_fwd_count", fwd_count, 3);

        // Load-use on R2
        drive(1, 1, 1, 2, 0, 0, 2'b00, 1, 0, 0);
        tick();
        drive(1, 0, 0, 0, 2, 0, 2'b01, 1, 0, 0);
        check("ld_stall", hazard_stall, 1);
        check("ld_sel_stalled", sel_src, 4'b0001);
        tick();
        check("ld_stall_count", stall_count, 1);
        drive(1, 0, 0, 0, 2, 0, 2'b01, 1, 0, 0);
        check("ld_release", hazard_stall, 0);
        check("ld_sel2", sel_src, 4'b0010);
        tick();
        check("ld_fwd_count", fwd_count, 4);

        // Forwarding disabled: two stall cycles on R4
        drive(1, 1, 0, 4, 0, 0, 2'b00, 0, 0, 0);
        tick();
        for (int n = 0; n < 2; n++) begin
            drive(1, 0, 0, 0, 4, 0, 2'b01, 0, 0, 0);
            check("nofwd_stall", hazard_stall, 1);
            check("nofwd_sel", sel_src, 0);
            tick();
        end
        drive(1, 0, 0, 0, 4, 0, 2'b01, 0, 0, 0);
        check("nofwd_release", hazard_stall, 0);
        tick();
        check("nofwd_stall_count", stall_count, 3);

        // Freeze holds the R7 producer in slot 1
        drive(1, 1, 0, 7, 0, 0, 2'b00, 1, 0, 0);
        tick();
        for (int n = 0; n < 3; n++) begin
            drive(1, 0, 0, 0, 7, 0, 2'b01, 1, 1, 0);
            check("frz_sel", sel_src, 4'b0001);
            tick();
            check("frz_fwd_count", fwd_count, 4);
        end
        drive(1, 0, 0, 0, 7, 0, 2'b01, 1, 0, 0);
        check("frz_after_sel", sel_src, 4'b0001);
        tick();
        check("frz_after_fwd", fwd_count, 5);

        // Flushed writer, and freeze beating flush
        drive(0, 0, 0, 0, 0, 0, 2'b00, 1, 0, 0);
        tick();
        tick();
        drive(1, 1, 0, 7, 0, 0, 2'b00, 1, 0, 1);
        tick();
        drive(1, 0, 0, 0, 7, 7, 2'b11, 1, 0, 0);
        check("flush_sel", sel_src, 0);
        tick();
        drive(1, 1, 0, 9, 0, 0, 2'b00, 1, 1, 1);
        tick();
        drive(1, 0, 0, 0, 9, 7, 2'b11, 1, 0, 0);
        check("frz_flush_sel", sel_src, 0);
        tick();

        // Randomized traffic over a small register space
        for (int n = 0; n < 400; n++) begin
            drive($urandom_range(3) != 0, $urandom_range(1), $urandom_range(1),
                  4'($urandom_range(3)), 4'($urandom_range(3)), 4'($urandom_range(3)),
                  2'($urandom_range(3)), $urandom_range(3) != 0,
                  $urandom_range(7) == 0, $urandom_range(7) == 0);
            tick();
        end

        // Asynchronous reset mid-operation
        drive(1, 1, 0, 1, 0, 0, 2'b00, 1, 0, 0);
        tick();
        drive(1, 1, 0, 1, 0, 0, 2'b00, 1, 0, 0);
        tick();
        drive(1, 0, 0, 0, 1, 1, 2'b11, 1, 0, 0);
        check("pre_rst_sel", sel_src, 4'b0101);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_sel", sel_src, 0);
        check("async_rst_stall", hazard_stall, 0);
        check("async_rst_stall_count", stall_count, 0);
        check("async_rst_fwd_count", fwd_count, 0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        drive(1, 0, 0, 0, 1, 1, 2'b11, 1, 0, 0);
        check("post_rst_sel", sel_src, 0);
        check("post_rst_stall", hazard_stall, 0);
        tick();

        // Saturation: a self-dependent writer with forwarding off stalls 31 of every 32 edges
        drive(0, 0, 0, 0, 0, 0, 2'b00, 1, 0, 0);
        s_en_forwarding = 0; s_issue_valid = 1; s_issue_wb_en = 1;
        s_issue_dst = 1; s_id_src = 8'h01; s_id_src_used = 2'b01;
        for (int e = 1; e <= SAT_EDGE; e++) begin
            @(posedge clk);
            if (e == 1000) begin
                #1;
                check("sat_mid_count", s_stall_count, 1000 - (1000 + SAT_D) / (SAT_D + 1));
                check("sat_mid_stall", s_hazard_stall, 1);
                check("sat_sel_zero", s_sel_src, 0);
            end
        end
        #1;
        check("sat_full", s_stall_count, 16'hFFFF);
        repeat (200) @(posedge clk);
        #1;
        check("sat_hold", s_stall_count, 16'hFFFF);
        check("sat_fwd_zero", s_fwd_count, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/forwarding_tracker.md
# forwarding_tracker

Parametrised forwarding and hazard unit for the ARM pipeline, driven by the issue point between ID and EXE. It keeps its own shift-register history of in-flight destinations, so pipeline-stage destination ports are not needed. Each cycle it produces per-source operand-select codes for any number of sources and forwarding depths. It also raises a load-use stall and keeps saturating performance counters.

## Interface
- `REG_ADDRESS_LEN`, 4: register address width.
- `NUM_SRC`, 2: number of source operands checked per issue.
- `FWD_DEPTH`, 2: number of tracked producer slots. Slot 1 holds the youngest producer.
- `LOAD_LAT`, 2: a load in slot k with k < `LOAD_LAT` cannot yet be forwarded.
- `SEL_W`, $clog2(`FWD_DEPTH`+1): width of one select code.
- `clk` in 1: clock. Only rising edges are used.
- `rst` in 1: asynchronous, active-high reset.
- `en_forwarding` in 1: 1 = forward; 0 = stall on any dependence.
- `freeze` in 1: pipeline frozen (memory wait). The tracker holds.
- `flush` in 1: branch flush. The instruction issuing this cycle is discarded.
- `issue_valid` in 1: an instruction is presented for issue.
- `issue_wb_en` in 1: the issuing instruction writes a register.
- `issue_mem_read` in 1: the issuing instruction is a load.
- `issue_dst` in `REG_ADDRESS_LEN`: destination of the issuing instruction.
- `id_src` in `NUM_SRC`*`REG_ADDRESS_LEN`: source addresses. Source i is in bits [i*W +: W].
- `id_src_used` in `NUM_SRC`: per-source valid mask.
- `sel_src` out `NUM_SRC`*`SEL_W`: per-source select. 0 = register file; k = result of slot k.
- `hazard_stall` out 1: the issuing instruction must be held.
- `stall_count` out 16: saturating count of stalled cycles.
- `fwd_count` out 16: saturating count of accepted issues with at least one nonzero select.

## Operation
- **Slot contents.** Each slot k in 1..`FWD_DEPTH` holds {valid, wb_en, mem_read, dst}.
- **Matching.** Source i matches slot k when all of these hold:
  - `id_src_used`[i] = 1
  - slot k valid = 1 and wb_en = 1
  - dst = source address
- **Priority.** The youngest match (lowest k) wins. An older match never overrides it.
- **Select, forwarding on.** With `en_forwarding`=1, `sel_src`[i] = k of the winning match, or 0 if there is no match.
- **Select, forwarding off.** With `en_forwarding`=0, `sel_src` is all 0.
- **Stall conditions.** `hazard_stall` = `issue_valid` AND (any used source meets condition (a) or (b)):
  - (a) `en_forwarding`=1 and its winning slot k has mem_read=1 and k < `LOAD_LAT`.
  - (b) `en_forwarding`=0 and it matches any slot.
- **Shift rule.** On each edge with `freeze`=0:
  - slot 1 <= {1, `issue_wb_en`, `issue_mem_read`, `issue_dst`} if the issue is accepted. Otherwise slot 1 <= bubble (valid=0).
  - An issue is accepted when `issue_valid`=1, `hazard_stall`=0 and `flush`=0.
  - slot k <= slot k-1 for k = 2..`FWD_DEPTH`. The oldest slot is dropped.
- **Freeze.** With `freeze`=1, no slot changes and no counter changes. Outputs are still evaluated from the current state.
- **Flush.** Affects only the slot-1 insertion. Older slots keep shifting normally.
- **`stall_count`.** Increments on edges with `freeze`=0, `issue_valid`=1 and `hazard_stall`=1. It saturates at 16'hFFFF.
- **`fwd_count`.** Increments on edges where an issue is accepted and any `sel_src` field is nonzero. It saturates at 16'hFFFF.
- **Reset.** `rst`=1 forces every slot valid=0 and both counters to 0. This applies immediately and asynchronously, including mid-stall. The other slot fields are don't-care.
- **Outputs after reset.** `sel_src`=0 and `hazard_stall`=0 for any inputs, until the first accepted issue.

## Timing
- `sel_src` and `hazard_stall` are combinational from the inputs and the registered slots. They are valid in the same cycle, with zero latency.
- A producer accepted at edge n appears in slot 1 after edge n and in slot k after edge n+k-1, counting only non-frozen edges.
- A load accepted at edge n causes a stall while it sits in slots 1..`LOAD_LAT`-1. With defaults, a dependent instruction stalls for exactly 1 cycle and then receives `sel_src`=2.
- A stalled instruction inserts a bubble into slot 1, so its dependence distance grows by one per stalled cycle.
- Simultaneous `freeze` and `flush`: `freeze` wins and nothing shifts.

## Test plan
- **Reset.** Assert `rst` mid-operation with slots full → `sel_src`=0, `hazard_stall`=0, both counters 0 immediately, before any clock edge.
- **Basic forwarding (defaults).** Issue a write to R3, then the next cycle issue src0=R3 and src1=R3 → `sel_src`={1,1}. One cycle later a reader of R3 gets 2; after 3 edges it gets 0.
- **Priority.** Issue writes to R5 twice back-to-back, then a reader of R5 → select 1, not 2. `fwd_count` increments by 1.
- **Load-use.** Issue a load to R2, then a reader of R2 → `hazard_stall`=1 for 1 cycle, then `sel_src`=2 and the issue is accepted. `stall_count`=1.
- **Forwarding disabled.** With `en_forwarding`=0, issue a write to R4, then a reader of R4 → stalls 2 cycles. `sel_src`=0 throughout and `stall_count`=2.
- **Freeze, flush and saturation.** Freeze for 3 cycles after a write to R7 → the reader of R7 keeps `sel_src`=1. A flushed write to R7 → no match. With `stall_count` preset to 16'hFFFF via a long stall, it stays 16'hFFFF.
